// File: rtl/gsm_pkg.sv
// Shared definitions for the GSM 4x4 switch output-side transfer logic.
// Holds the transfer FSM encoding, default geometry and counter widths.
// Imported by gsm_onehot_enc and gsm_xfer_ctrl.
package gsm_pkg;

    // Default switch geometry (one scheduler group per output port).
    localparam int NUM_PORT_DEF  = 4;
    localparam int LOG_PORT_DEF  = 2;
    localparam int DWIDTH_DEF    = 32;

    // Completed-packet counter width; wraps naturally at 2^PKT_CNT_W.
    localparam int PKT_CNT_W     = 16;

    // Transfer FSM encoding. Kept as plain constants so the encoding is
    // visible on waveforms and stable across tool flows.
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_XFER = 1'b1;

    typedef logic [0:0] xfer_state_t;

endpackage

// File: rtl/gsm_onehot_enc.sv
// Lowest-set-bit index encoder with multi-hot detection, for scheduler grants.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows input every cycle.
//
// Ports:
//   vec_i   : request/grant vector
//   idx_o   : index of the lowest set bit (0 when vec_i is zero)
//   any_o   : at least one bit set
//   multi_o : more than one bit set
module gsm_onehot_enc
    import gsm_pkg::*;
#(
    parameter int N    = NUM_PORT_DEF,
    parameter int LOGN = LOG_PORT_DEF
)
(
    input  logic [N-1:0]    vec_i,
    output logic [LOGN-1:0] idx_o,
    output logic            any_o,
    output logic            multi_o
);

    logic seen;

    always_comb begin
        idx_o   = '0;
        any_o   = 1'b0;
        multi_o = 1'b0;
        seen    = 1'b0;
        // Scan from the top down so the last write is the lowest set bit.
        for (int i = N - 1; i >= 0; i--) begin
            if (vec_i[i]) begin
                idx_o = LOGN'(i);
            end
        end
        for (int i = 0; i < N; i++) begin
            if (vec_i[i]) begin
                if (seen) begin
                    multi_o = 1'b1;
                end
                seen = 1'b1;
            end
        end
        any_o = seen;
    end

endmodule

// File: rtl/gsm_xfer_ctrl.sv
// Per-output-port packet transfer controller behind one round-robin scheduler.
// Latency: grant at T, first word valid at T+1, registered output word at T+2.
// Backpressure: out_ready low holds the output register and drops in_ready.
//
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   clr          : synchronous clear, aborts any transfer and zeroes counters
//   grant        : one-hot grant from the scheduler (sampled only when idle)
//   stall        : held high to the scheduler for the whole packet
//   in_data/in_valid/in_eop/in_ready : per-queue word interface, queue k at
//                  in_data[k*DWIDTH +: DWIDTH]; only the locked queue sees ready
//   out_data/out_valid/out_sop/out_eop/out_ready : registered output stage
//   pkt_cnt      : completed packets (normal or length-aborted), wraps
//   err          : sticky, multi-hot grant seen or packet length abort
module gsm_xfer_ctrl
    import gsm_pkg::*;
#(
    parameter int NUM_PORT     = 4,
    parameter int LOG_NUM_PORT = 2,
    parameter int DWIDTH       = 32,
    parameter int MAX_BEATS    = 64,
    parameter int BWIDTH       = 7
)
(
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clr,
    input  logic [NUM_PORT-1:0]          grant,
    output logic                         stall,
    input  logic [NUM_PORT*DWIDTH-1:0]   in_data,
    input  logic [NUM_PORT-1:0]          in_valid,
    input  logic [NUM_PORT-1:0]          in_eop,
    output logic [NUM_PORT-1:0]          in_ready,
    output logic [DWIDTH-1:0]            out_data,
    output logic                         out_valid,
    output logic                         out_sop,
    output logic                         out_eop,
    input  logic                         out_ready,
    output logic [PKT_CNT_W-1:0]         pkt_cnt,
    output logic                         err
);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    xfer_state_t               state_q, state_d;
    logic [LOG_NUM_PORT-1:0]   sel_q, sel_d;
    logic [BWIDTH-1:0]         beats_q, beats_d;
    logic [DWIDTH-1:0]         out_data_q, out_data_d;
    logic                      out_valid_q, out_valid_d;
    logic                      out_sop_q, out_sop_d;
    logic                      out_eop_q, out_eop_d;
    logic [PKT_CNT_W-1:0]      pkt_cnt_q, pkt_cnt_d;
    logic                      err_q, err_d;

    // ------------------------------------------------------------------
    // Grant decode
    // ------------------------------------------------------------------
    logic [LOG_NUM_PORT-1:0]   gnt_idx;
    logic                      gnt_any;
    logic                      gnt_multi;

    gsm_onehot_enc #(
        .N    (NUM_PORT),
        .LOGN (LOG_NUM_PORT)
    ) u_gnt_enc (
        .vec_i   (grant),
        .idx_o   (gnt_idx),
        .any_o   (gnt_any),
        .multi_o (gnt_multi)
    );

    // ------------------------------------------------------------------
    // Selected-queue view and handshakes
    // ------------------------------------------------------------------
    logic [DWIDTH-1:0]         sel_data;
    logic                      sel_valid;
    logic                      sel_eop;
    logic                      in_xfer;
    logic                      out_free;
    logic                      beat;
    logic                      len_limit;
    logic                      pkt_end;

    assign sel_data  = in_data[int'(sel_q) * DWIDTH +: DWIDTH];
    assign sel_valid = in_valid[sel_q];
    assign sel_eop   = in_eop[sel_q];

    assign in_xfer   = (state_q == ST_XFER);
    // Output register can take a word if empty or being drained this cycle.
    assign out_free  = !out_valid_q || out_ready;
    assign beat      = in_xfer && out_free && sel_valid;
    // Reaching the last allowed beat without eop terminates the packet.
    assign len_limit = (beats_q == BWIDTH'(MAX_BEATS - 1));
    assign pkt_end   = sel_eop || len_limit;

    always_comb begin
        in_ready = '0;
        if (in_xfer && out_free) begin
            in_ready[sel_q] = 1'b1;
        end
    end

    // Scheduler pointer must hold for exactly the packet's lifetime.
    assign stall = in_xfer;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        beats_d     = beats_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_sop_d   = out_sop_q;
        out_eop_d   = out_eop_q;
        pkt_cnt_d   = pkt_cnt_q;
        err_d       = err_q;

        if (clr) begin
            // Partial packet is dropped with no eop; grant in this cycle is lost.
            state_d     = ST_IDLE;
            beats_d     = '0;
            out_valid_d = 1'b0;
            out_sop_d   = 1'b0;
            out_eop_d   = 1'b0;
            pkt_cnt_d   = '0;
            err_d       = 1'b0;
        end else begin
            // Downstream took the held word; a new beat below may refill it.
            if (out_ready) begin
                out_valid_d = 1'b0;
                out_sop_d   = 1'b0;
                out_eop_d   = 1'b0;
            end

            case (state_q)
                ST_IDLE: begin
                    if (gnt_any) begin
                        sel_d   = gnt_idx;
                        beats_d = '0;
                        state_d = ST_XFER;
                        if (gnt_multi) begin
                            err_d = 1'b1;
                        end
                    end
                end
                ST_XFER: begin
                    if (beat) begin
                        out_data_d  = sel_data;
                        out_valid_d = 1'b1;
                        out_sop_d   = (beats_q == '0);
                        out_eop_d   = pkt_end;
                        if (beats_q != BWIDTH'(MAX_BEATS)) begin
                            beats_d = beats_q + 1'b1;
                        end
                        if (pkt_end) begin
                            state_d   = ST_IDLE;
                            pkt_cnt_d = pkt_cnt_q + 1'b1;
                            if (!sel_eop) begin
                                err_d = 1'b1;
                            end
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            sel_q       <= '0;
            beats_q     <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_sop_q   <= 1'b0;
            out_eop_q   <= 1'b0;
            pkt_cnt_q   <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            beats_q     <= beats_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_sop_q   <= out_sop_d;
            out_eop_q   <= out_eop_d;
            pkt_cnt_q   <= pkt_cnt_d;
            err_q       <= err_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_sop   = out_sop_q;
    assign out_eop   = out_eop_q;
    assign pkt_cnt   = pkt_cnt_q;
    assign err       = err_q;

endmodule

// File: tb/tb_gsm_xfer_ctrl.sv
module tb_gsm_xfer_ctrl;

    localparam int NP   = 4;
    localparam int DW   = 32;
    localparam int MAXB = 64;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 clr;
    logic [NP-1:0]        grant;
    logic                 stall;
    logic [NP*DW-1:0]     in_data;
    logic [NP-1:0]        in_valid;
    logic [NP-1:0]        in_eop;
    logic [NP-1:0]        in_ready;
    logic [DW-1:0]        out_data;
    logic                 out_valid;
    logic                 out_sop;
    logic                 out_eop;
    logic                 out_ready;
    logic [15:0]          pkt_cnt;
    logic                 err;

    always #5 clk = ~clk;

    gsm_xfer_ctrl #(
        .NUM_PORT     (NP),
        .LOG_NUM_PORT (2),
        .DWIDTH       (DW),
        .MAX_BEATS    (MAXB),
        .BWIDTH       (7)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .grant     (grant),
        .stall     (stall),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_eop    (in_eop),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_sop   (out_sop),
        .out_eop   (out_eop),
        .out_ready (out_ready),
        .pkt_cnt   (pkt_cnt),
        .err       (err)
    );

    // Expected output beats, in delivery order.
    typedef struct packed {
        logic [DW-1:0] d;
        logic          s;
        logic          e;
    } beat_t;
    beat_t exp_q[$];

    // Input queue contents: words and eop markers, head/tail per queue.
    logic [DW-1:0] wmem [NP][256];
    logic          emem [NP][256];
    int            head [NP];
    int            tail [NP];

    int total = 0;
    int bad   = 0;

    // Reference model: packet-level view of the controller.
    bit          mbusy  = 1'b0;
    bit          mabort = 1'b0;
    bit          mov    = 1'b0;
    bit          merr   = 1'b0;
    int          msel   = 0;
    int          mleft  = 0;
    logic [15:0] mcnt   = '0;

    int ord_mode = 0;   // 0: out_ready=1, 1: random, 2: out_ready=0
    bit gaps     = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic load_pkt(input int q, input int len, input bit with_eop);
        if (head[q] == tail[q]) begin
            head[q] = 0;
            tail[q] = 0;
        end
        for (int i = 0; i < len; i++) begin
            wmem[q][tail[q]] = $urandom;
            emem[q][tail[q]] = with_eop && (i == len - 1);
            tail[q]++;
        end
    endtask

    // Grant accepted: lowest set bit wins; packet = words up to eop, max MAXB.
    task automatic start_pkt();
        int    q;
        int    len;
        beat_t b;
        q = 0;
        for (int i = NP - 1; i >= 0; i--) begin
            if (grant[i]) q = i;
        end
        if ($countones(grant) > 1) merr = 1'b1;
        len = 0;
        while (len < MAXB && head[q] + len < tail[q]) begin
            len++;
            if (emem[q][head[q] + len - 1]) break;
        end
        mabort = (len == MAXB) && !emem[q][head[q] + len - 1];
        for (int i = 0; i < len; i++) begin
            b.d = wmem[q][head[q] + i];
            b.s = (i == 0);
            b.e = (i == len - 1);
            exp_q.push_back(b);
        end
        msel  = q;
        mleft = len;
        mbusy = 1'b1;
    endtask

    // One clock cycle; called at posedge+1 with grant/clr already set.
    task automatic tick();
        logic [NP-1:0] popv;
        logic [NP-1:0] exp_rdy;
        beat_t         b;
        for (int k = 0; k < NP; k++) begin
            if (head[k] < tail[k]) begin
                in_valid[k]          = !gaps || ($urandom_range(3) != 0);
                in_data[k*DW +: DW]  = wmem[k][head[k]];
                in_eop[k]            = emem[k][head[k]];
            end else begin
                in_valid[k]          = 1'b0;
                in_data[k*DW +: DW]  = '0;
                in_eop[k]            = 1'b0;
            end
        end
        out_ready = (ord_mode == 0) ? 1'b1 :
                    (ord_mode == 2) ? 1'b0 : ($urandom_range(2) != 0);
        #1;
        exp_rdy = '0;
        if (mbusy && (!mov || out_ready)) exp_rdy[msel] = 1'b1;
        chk("in_ready",  64'(in_ready),  64'(exp_rdy));
        chk("stall",     64'(stall),     64'(mbusy));
        chk("out_valid", 64'(out_valid), 64'(mov));
        chk("pkt_cnt",   64'(pkt_cnt),   64'(mcnt));
        chk("err",       64'(err),       64'(merr));
        popv = in_valid & in_ready;
        if (out_valid && out_ready) begin
            chk("beat_pending", 64'(exp_q.size() != 0), 64'(1));
            if (exp_q.size() != 0) begin
                b = exp_q.pop_front();
                chk("out_data", 64'(out_data), 64'(b.d));
                chk("out_sop",  64'(out_sop),  64'(b.s));
                chk("out_eop",  64'(out_eop),  64'(b.e));
            end
        end
        if (clr) begin
            mbusy = 1'b0;
            mov   = 1'b0;
            mcnt  = '0;
            merr  = 1'b0;
            exp_q.delete();
        end else begin
            if (mbusy) begin
                if (popv[msel]) begin
                    mleft--;
                    if (mleft == 0) begin
                        mbusy = 1'b0;
                        mcnt++;
                        if (mabort) merr = 1'b1;
                    end
                end
            end else if (grant != '0) begin
                start_pkt();
            end
            if (popv != '0)     mov = 1'b1;
            else if (out_ready) mov = 1'b0;
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < NP; k++) begin
            if (popv[k]) head[k]++;
        end
    endtask

    task automatic grant_once(input logic [NP-1:0] g);
        grant = g;
        tick();
        grant = '0;
    endtask

    task automatic drain(input int maxc);
        int n;
        n = 0;
        while ((mbusy || mov || exp_q.size() != 0) && n < maxc) begin
            tick();
            n++;
        end
        chk("drain_idle", 64'({stall, out_valid, exp_q.size() != 0}), 64'(0));
    endtask

    task automatic clr_pulse();
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL global_timeout");
        $fatal(1, "simulation time limit");
    end

    initial begin
        logic [DW-1:0] hold_d;
        int            h3;
        int            start;
        int            n;
        logic [NP-1:0] g;

        rst       = 1'b1;
        clr       = 1'b0;
        grant     = '0;
        in_data   = '0;
        in_valid  = '0;
        in_eop    = '0;
        out_ready = 1'b1;
        for (int k = 0; k < NP; k++) begin
            head[k] = 0;
            tail[k] = 0;
        end

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        chk("rst_stall",     64'(stall),     64'(0));
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_out_data",  64'(out_data),  64'(0));
        chk("rst_in_ready",  64'(in_ready),  64'(0));
        chk("rst_pkt_cnt",   64'(pkt_cnt),   64'(0));
        chk("rst_err",       64'(err),       64'(0));
        rst = 1'b0;
        tick();

        // Single 3-word packet from queue 2
        load_pkt(2, 3, 1'b1);
        grant_once(4'b0100);
        drain(50);
        chk("single_pkt_cnt", 64'(pkt_cnt), 64'(1));
        chk("single_err",     64'(err),     64'(0));

        // Backpressure for 4 cycles in the middle of a 5-word packet
        load_pkt(0, 5, 1'b1);
        grant_once(4'b0001);
        tick();
        tick();
        hold_d   = out_data;
        ord_mode = 2;
        repeat (4) begin
            tick();
            chk("bp_data_hold",  64'(out_data),  64'(hold_d));
            chk("bp_valid_hold", 64'(out_valid), 64'(1));
        end
        ord_mode = 0;
        drain(50);
        chk("bp_pkt_cnt", 64'(pkt_cnt), 64'(2));

        // Multi-hot grant picks the lowest index and flags err
        load_pkt(1, 3, 1'b1);
        load_pkt(3, 2, 1'b1);
        h3 = head[3];
        grant_once(4'b1010);
        drain(50);
        chk("multi_err",     64'(err),             64'(1));
        chk("multi_q3_kept", 64'(head[3]),         64'(h3));
        chk("multi_q1_done", 64'(tail[1] - head[1]), 64'(0));
        clr_pulse();
        chk("clr_err", 64'(err), 64'(0));

        // Length abort: 70 words without eop
        load_pkt(0, 70, 1'b0);
        grant_once(4'b0001);
        drain(300);
        chk("abort_left",  64'(tail[0] - head[0]), 64'(6));
        chk("abort_err",   64'(err),   64'(1));
        chk("abort_idle",  64'(stall), 64'(0));
        chk("abort_count", 64'(pkt_cnt), 64'(1));
        head[0] = tail[0];
        clr_pulse();

        // Back-to-back: queue 0 then queue 3 (already holding a 2-word packet)
        load_pkt(0, 3, 1'b1);
        grant_once(4'b0001);
        grant = 4'b1000;
        n = 0;
        while (mcnt != 16'd2 && n < 100) begin
            tick();
            n++;
        end
        grant = '0;
        drain(50);
        chk("b2b_pkt_cnt", 64'(pkt_cnt), 64'(2));
        chk("b2b_q3_done", 64'(tail[3] - head[3]), 64'(0));

        // clr and grant together: clr wins
        head[2] = tail[2];
        load_pkt(2, 2, 1'b1);
        grant = 4'b0100;
        clr_pulse();
        grant = '0;
        tick();
        chk("clr_gnt_stall",  64'(stall),   64'(0));
        chk("clr_gnt_cnt",    64'(pkt_cnt), 64'(0));

        // Pad the count so the mid-packet clear has something to zero
        grant_once(4'b0100);
        drain(50);

        // clr after 2 of 4 words
        load_pkt(2, 4, 1'b1);
        start = head[2];
        grant_once(4'b0100);
        n = 0;
        while (head[2] - start < 2 && n < 20) begin
            tick();
            n++;
        end
        clr_pulse();
        chk("clr_mid_valid", 64'(out_valid), 64'(0));
        chk("clr_mid_stall", 64'(stall),     64'(0));
        chk("clr_mid_cnt",   64'(pkt_cnt),   64'(0));
        head[2] = tail[2];
        tick();

        // Async reset in the middle of a packet
        load_pkt(1, 4, 1'b1);
        grant_once(4'b0010);
        tick();
        tick();
        rst = 1'b1;
        #1;
        chk("arst_out_valid", 64'(out_valid), 64'(0));
        chk("arst_stall",     64'(stall),     64'(0));
        chk("arst_out_data",  64'(out_data),  64'(0));
        chk("arst_out_sop",   64'(out_sop),   64'(0));
        chk("arst_in_ready",  64'(in_ready),  64'(0));
        mbusy = 1'b0;
        mov   = 1'b0;
        mcnt  = '0;
        merr  = 1'b0;
        exp_q.delete();
        head[1] = tail[1];
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick();

        // Randomised packets, valid gaps and output backpressure
        gaps     = 1'b1;
        ord_mode = 1;
        repeat (30) begin
            g = 4'($urandom_range(1, 15));
            for (int k = 0; k < NP; k++) begin
                if (g[k] && head[k] == tail[k]) load_pkt(k, $urandom_range(1, 8), 1'b1);
            end
            grant_once(g);
            drain(400);
            repeat ($urandom_range(0, 2)) tick();
        end
        chk("rand_pkt_cnt", 64'(pkt_cnt), 64'(mcnt));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/gsm_xfer_ctrl.md
Name: gsm_xfer_ctrl

Overview:
- Per-output-port packet transfer controller. It sits directly downstream of one round-robin scheduler instance in the GSM 4x4 switch.
- It consumes the scheduler's one-hot grant, locks onto the granted input queue, and streams one packet from that queue to the output port through a registered output stage.
- It drives the scheduler's stall input high for the whole packet, so the grant pointer holds until end-of-packet.

Parameters:
NUM_PORT, 4, number of input queues (matches scheduler group size)
LOG_NUM_PORT, 2, log2(NUM_PORT)
DWIDTH, 32, data word width
MAX_BEATS, 64, maximum beats per packet before forced abort
BWIDTH, 7, beat counter width (must hold MAX_BEATS)

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
clr  in  1  synchronous clear: abort transfer, clear counters/flags
grant  in  NUM_PORT  one-hot grant from scheduler
stall  out  1  to scheduler; high while a packet is in progress
in_data  in  NUM_PORT*DWIDTH  input queue words; queue k occupies bits [k*DWIDTH +: DWIDTH]
in_valid  in  NUM_PORT  per-queue word valid
in_eop  in  NUM_PORT  per-queue end-of-packet marker
in_ready  out  NUM_PORT  per-queue pop; at most one bit high
out_data  out  DWIDTH  registered output word
out_valid  out  1  output word valid
out_sop  out  1  first beat of packet
out_eop  out  1  last beat of packet
out_ready  in  1  downstream accept
pkt_cnt  out  16  packets completed, wraps at 2^16
err  out  1  sticky: multi-hot grant or length abort

Behaviour:
- Reset (async, rst=1): state=IDLE; stall, out_valid, out_sop, out_eop, in_ready, err=0; out_data=0; pkt_cnt=0; sel=0; beats=0.
- Transfer handshake: a beat moves when in_valid[sel] & in_ready[sel]. The output handshake is out_valid & out_ready.
- in_ready[sel] = (state==XFER) & (!out_valid | out_ready). All other in_ready bits are 0. It is combinational from registered state and out_ready.
- IDLE:
  - grant!=0 at cycle T → latch sel = index of the lowest set bit; state=XFER at T+1; stall=1 from T+1.
  - If popcount(grant)>1, set err at T+1 and still use the lowest index.
  - grant==0 → stay in IDLE.
- XFER:
  - Each accepted beat loads out_data/out_valid=1 on the next edge.
  - out_sop=1 only when beats==0. beats increments, saturating at MAX_BEATS.
  - Beat with in_eop[sel]=1 → out_eop=1, pkt_cnt+1, state=IDLE, stall=0 on the same edge. The earliest new grant is accepted the following cycle.
  - beats==MAX_BEATS-1 and in_eop=0 → force out_eop=1, set err, pkt_cnt+1, return to IDLE. Remaining words stay in the queue.
  - grant is ignored in XFER.
- Output register:
  - out_valid clears when out_ready=1 and no new beat is loaded.
  - When out_ready=0, out_* hold stable.
  - Back-to-back beats with out_ready=1 give full throughput.
- Latency: grant at T, in_valid at T+1 → out_valid at T+2.
- in_valid low mid-packet: controller waits in XFER, stall stays 1.
- clr (overrides all but rst):
  - next edge: state=IDLE, stall=0, out_valid=0, beats=0, pkt_cnt=0, err=0.
  - A partial packet is dropped without eop.
- rst mid-packet: immediate async return to reset values.
- Simultaneous clr and grant: clr wins; the grant is not latched.

Decomposition:
- Shared package gsm_pkg: state encoding (IDLE=1'b0, XFER=1'b1), DWIDTH/NUM_PORT defaults, PKT_CNT_W=16.
- One natural sub-module, gsm_onehot_enc: lowest-set-bit index encoder with multi-hot flag. It is reusable by the scheduler wrappers.

Test Plan:
- Single packet: grant=4'b0100, queue 2 presents 3 words (eop on third), out_ready=1 → in_ready=4'b0100 from T+1; out_sop on word0, out_eop on word2; stall high T+1..T+3; pkt_cnt=1, err=0.
- Backpressure: out_ready low for 4 cycles mid-packet → out_data/out_valid stable, in_ready[sel]=0, no word lost or duplicated (compare 5-word sequence).
- Multi-hot grant=4'b1010 → sel=1, err=1, packet from queue 1 only.
- Length abort: MAX_BEATS=64, queue 0 sends 70 words without eop → out_eop on beat 64, err=1, state IDLE, words 65..70 not popped.
- Back-to-back: two packets granted consecutively (queues 0 then 3) → second grant accepted the cycle after the first eop; pkt_cnt=2; no beat interleaving.
- clr mid-packet (after 2 of 4 words) → next cycle out_valid=0, stall=0, pkt_cnt=0; assert rst mid-packet → outputs zero immediately without a clock edge.
